// File: rtl/multi_cycle_shift_pkg.sv
// Shared types for the multi-cycle right shifter: the controller state encoding.
package multi_cycle_shift_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/right_shift_of_N_by_S_using_right_shift_operation.sv
// Combinational fixed-distance logical right shift of an N-bit word by S bits.
module right_shift_of_N_by_S_using_right_shift_operation #(
  parameter int unsigned N = 8,
  parameter int unsigned S = 1
) (
  input  logic [N-1:0] in_i,
  output logic [N-1:0] out_o
);

  assign out_o = in_i >> S;

endmodule

// File: rtl/multi_cycle_right_shift.sv
// Serial right shifter: one bit per cycle, valid/ready on both sides.
// Define MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN to add the arith input (sign-filling shift).
module multi_cycle_right_shift
  import multi_cycle_shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
  input  logic          arith,
`endif
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  res,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  step_out;
  logic [N-1:0]  shifted;

  right_shift_of_N_by_S_using_right_shift_operation #(
    .N (N),
    .S (1)
  ) u_step (
    .in_i  (data_q),
    .out_o (step_out)
  );

`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
  logic arith_q, arith_d;

  // The step always zero-fills; an arithmetic shift replaces that MSB with the sign.
  assign shifted = {(arith_q & data_q[N-1]), step_out[N-2:0]};
`else
  assign shifted = step_out;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
    arith_d = arith_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (up_valid) begin
          data_d  = a;
          cnt_d   = shamt;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
          arith_d = arith;
`endif
          state_d = (shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d = shifted;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = StDone;
      end
      StDone: begin
        if (down_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
      arith_q <= arith_d;
`endif
    end
  end

  assign up_ready   = (state_q == StIdle);
  assign down_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign res        = data_q;

endmodule

// File: tb/tb_multi_cycle_right_shift.sv
// Directed plus random scoreboard bench for multi_cycle_right_shift (N=8).
// Honours MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN when the design is built with it.
module tb_multi_cycle_right_shift;

  logic       clk;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] a;
  logic [2:0] shamt;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] res;
  logic       busy;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
  logic       arith;
`endif

  typedef struct {
    logic [7:0] r;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  multi_cycle_right_shift #(
    .N  (8),
    .SW (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .a          (a),
    .shamt      (shamt),
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
    .arith      (arith),
`endif
    .down_valid (down_valid),
    .down_ready (down_ready),
    .res        (res),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic do_op(input logic [7:0] av, input logic [2:0] sv, input logic arv,
                       input int stall, input logic pulse_uv);
    exp_t e;
    int   lat;
    e.r   = arv ? 8'($signed(av) >>> sv) : (av >> sv);
    e.lat = int'(sv) + 1;
    up_valid   = 1'b1;
    a          = av;
    shamt      = sv;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
    arith      = arv;
`endif
    down_ready = 1'($urandom);
    check("up_ready_before_accept", 32'(up_ready), 32'd1);
    sb.push_back(e);
    @(negedge clk);
    up_valid = 1'b0;
    a        = 8'($urandom);
    shamt    = 3'($urandom);
    lat      = 1;
    while (!down_valid && lat < 20) begin
      down_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("down_valid_seen", 32'(down_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    for (int i = 0; i < stall; i++) begin
      down_ready = 1'b0;
      up_valid   = pulse_uv & 1'($urandom);
      a          = 8'($urandom);
      shamt      = 3'($urandom);
      @(negedge clk);
      check("stall_res_stable", 32'(res), 32'(e.r));
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_down_valid", 32'(down_valid), 32'd1);
    end
    up_valid   = 1'b0;
    down_ready = 1'b1;
    check("res", 32'(res), 32'(e.r));
    @(negedge clk);
    check("up_ready_after", 32'(up_ready), 32'd1);
    check("down_valid_after", 32'(down_valid), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_dv;
    logic [7:0] ra;
    logic [2:0] rs;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    a          = 8'hA5;
    shamt      = 3'd5;
    down_ready = 1'b0;
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
    arith      = 1'b0;
`endif
    #3;
    check("rst_up_ready", 32'(up_ready), 32'd1);
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release must accept.
    do_op(8'hB4, 3'd3, 1'b0, 0, 1'b0);
    do_op(8'hFF, 3'd0, 1'b0, 0, 1'b0);
    do_op(8'h80, 3'd7, 1'b0, 5, 1'b1);

    // Abort during SHIFT.
    up_valid = 1'b1;
    a        = 8'hC3;
    shamt    = 3'd6;
    @(negedge clk);
    up_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_up_ready", 32'(up_ready), 32'd1);
    check("abort_down_valid", 32'(down_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_res", 32'(res), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    seen_dv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_dv |= down_valid;
    end
    check("no_down_valid_after_abort", 32'(seen_dv), 32'd0);
    do_op(8'h5A, 3'd2, 1'b0, 1, 1'b0);

`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
    do_op(8'h90, 3'd2, 1'b1, 0, 1'b0);
    do_op(8'h90, 3'd2, 1'b0, 0, 1'b0);
`endif

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rs = 3'($urandom);
`ifdef MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN
      do_op(ra, rs, 1'($urandom), $urandom_range(0, 3), 1'b1);
`else
      do_op(ra, rs, 1'b0, $urandom_range(0, 3), 1'b1);
`endif
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_right_shift.md
MULTI_CYCLE_RIGHT_SHIFT -- requirements
Module: multi_cycle_right_shift

Interface
REQ-001 SHALL have parameter N, default 8: operand and result width in bits (N >= 2).
REQ-002 SHALL have parameter SW, default $clog2(N): shift-amount width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port up_valid  input  1  operand/amount offered.
REQ-007 SHALL have port up_ready  output  1  block can accept an operand.
REQ-008 SHALL have port a  input  N  unsigned operand.
REQ-009 SHALL have port shamt  input  SW  right-shift amount.
REQ-010 SHALL have port down_valid  output  1  result available.
REQ-011 SHALL have port down_ready  input  1  consumer takes the result.
REQ-012 SHALL have port res  output  N  shifted result.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 SHALL drive up_ready = (state == IDLE) and down_valid = (state == DONE), both purely decoded from state.
REQ-016 SHALL accept on up_valid && up_ready: load a into the data register and shamt into the counter.
REQ-017 On accept, SHALL go to DONE if shamt == 0, else to SHIFT.
REQ-018 In each SHIFT cycle, SHALL shift the data register right by one bit, fill the MSB with 0, and decrement the counter.
REQ-019 SHALL leave SHIFT for DONE on the edge where the counter goes from 1 to 0.
REQ-020 Latency: down_valid SHALL rise exactly shamt+1 cycles after the accepting edge.
REQ-021 SHALL drive res from the data register at all times, and res SHALL be stable while down_valid && !down_ready.
REQ-022 SHALL return to IDLE on down_valid && down_ready; there is no accept in the same cycle, so the minimum throughput is one operation per shamt+2 cycles.
REQ-023 SHALL ignore up_valid outside IDLE; a, shamt, up_valid and down_ready SHALL have no effect in the states where they are not sampled.
REQ-024 If N is not a power of two, shamt >= N SHALL yield all-fill-bits, with no special-case logic.
REQ-025 The result SHALL equal a >> shamt, bit-exact for every input.

Reset
REQ-026 While rst_n is low, SHALL set state = IDLE, data register = 0, counter = 0, up_ready = 1, down_valid = 0, busy = 0 and res = 0, asynchronously.
REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation and produce no down_valid after release.
REQ-028 The first accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-029 SHALL use macro MULTI_CYCLE_RIGHT_SHIFT_ARITH_EN; when defined, an extra input arith (1 bit, sampled at accept, held in a flag register) SHALL make each SHIFT step replicate the sign bit (MSB) instead of shifting in 0, so res == $signed(a) >>> shamt.
REQ-030 Without the macro, the arith port and flag SHALL not exist and behaviour SHALL be logical shift only.

Structure
REQ-031 SHALL declare the state enum type (2-bit: IDLE, SHIFT, DONE) in package multi_cycle_shift_pkg; the module imports it.
REQ-032 SHALL implement the one-bit step as an instance of right_shift_of_N_by_S_using_right_shift_operation with S = 1; with ARITH_EN, the MSB of its output SHALL be overridden by the sign fill.
REQ-033 SHALL contain no other sub-modules, and SHALL have a single registered datapath (data register, counter, state).

Verification
REQ-034 Reset then a=8'hB4, shamt=3, up_valid for one cycle, down_ready=1 -> down_valid 4 cycles after accept, res=8'h16, then up_ready=1 next cycle.
REQ-035 a=8'hFF, shamt=0 -> down_valid 1 cycle after accept, res=8'hFF.
REQ-036 a=8'h80, shamt=7, down_ready=0 for 5 cycles after down_valid -> res=8'h01 held stable, busy=1, up_valid pulses ignored, completion on the down_ready edge.
REQ-037 rst_n pulsed low during SHIFT (shamt=6, 2 cycles in) -> outputs at reset values immediately, no down_valid afterward, and a new accept works.
REQ-038 With ARITH_EN: a=8'h90, shamt=2, arith=1 -> res=8'hE4; arith=0 -> res=8'h24.
REQ-039 Random a/shamt, 1000 operations with random down_ready stalls -> every res == a >> shamt, and latency == shamt+1.
